fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction-queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0, word address fetched first after reset.
REQ-003 clk1  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req  output  1  instruction-memory read request, held until imem_ack.
REQ-006 imem_addr  output  32  word address of the request; stable while imem_req=1.
REQ-007 imem_ack  input  1  imem_rdata valid this cycle; completes the request.
REQ-008 imem_rdata  input  32  instruction word returned.
REQ-009 redirect_valid  input  1  taken branch from execute; single-cycle pulse.
REQ-010 redirect_pc  input  32  branch target word address.
REQ-011 ir_valid  output  1  queue head holds an instruction.
REQ-012 ir  output  32  head instruction, feeds the IF/ID instruction register.
REQ-013 npc  output  32  head instruction address + 1, feeds the IF/ID next-PC register.
REQ-014 ir_ready  input  1  consumer takes the head when ir_valid=1 and ir_ready=1.
REQ-015 halted  output  1  HLT instruction has been consumed; sticky.

Function
REQ-016 FSM states: IDLE (no request outstanding), BUSY (request outstanding), DISCARD (request outstanding, response to be dropped), STOP (HLT enqueued, no fetching).
REQ-017 IDLE->BUSY when count + 0 < DEPTH and not halted: assert imem_req with imem_addr = pc.
REQ-018 BUSY on imem_ack: push {imem_rdata, pc+1}, pc <= pc+1; go to STOP if imem_rdata[31:26]=6'b111111, else IDLE.
REQ-019 Only one request is outstanding at a time; a request is issued only if a free entry is reserved, so a push never overflows.
REQ-020 Pushed entry appears at ir_valid the cycle after imem_ack; minimum fetch-to-output latency is 1 cycle after ack.
REQ-021 Head pops on ir_valid & ir_ready; push and pop in the same cycle are both honoured, count unchanged.
REQ-022 Empty: ir_valid=0, ir/npc hold their last value; ir_ready ignored.
REQ-023 redirect_valid: flush all entries (count<=0), pc <= redirect_pc; any same-cycle pop or push is discarded.
REQ-024 Redirect in BUSY without same-cycle ack -> DISCARD; imem_req stays high with the old address until ack, that data is dropped, then -> IDLE.
REQ-025 Redirect in STOP -> IDLE (HLT was on the wrong path) unless halted=1.
REQ-026 Redirect in DISCARD: update pc, remain in DISCARD.
REQ-027 halted <= 1 when a popped head has opcode 6'b111111; once set, no further requests and redirects are ignored until reset.
REQ-028 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-029 pc arithmetic is 32-bit and wraps from 32'hFFFFFFFF to 0.

Reset
REQ-030 rst_n=0 forces, asynchronously: state=IDLE, pc=RESET_PC, count=0, pointers=0, imem_req=0, imem_addr=RESET_PC, ir_valid=0, ir=0, npc=0, halted=0.
REQ-031 Reset mid-request abandons it; an imem_ack arriving in the first cycle after reset is ignored.
REQ-032 First request is issued in the first clk1 edge after rst_n deasserts.

Structure
REQ-033 Opcode constants (HLT=6'b111111, BEQZ, BNEQZ) and FSM state encoding belong in the shared package pipe_pkg.
REQ-034 Storage and pointers are implemented in one sub-module fq_fifo (push, pop, flush, full, empty, count); FSM and PC live in fetch_queue.

Verification
REQ-035 Reset, imem_ack 1 cycle after every request, ir_ready=1, mem[0..2]=ADDI words -> ir/npc sequence (2801000a,1),(28020014,2),(28030019,3).
REQ-036 ir_ready=0, zero-wait memory -> exactly 4 entries accepted, imem_req stays 0 after the 4th push; one pop -> one new request at address 4.
REQ-037 Redirect to 20 while request to 5 is outstanding -> data for 5 dropped, next imem_addr=20, first ir=mem[20] with npc=21.
REQ-038 mem[8]=fc000000 -> no request to 9, halted=1 the cycle after HLT pops, ir_valid=0 thereafter.
REQ-039 HLT enqueued then redirect to 0 before pop -> HLT flushed, halted=0, fetching resumes at 0.
REQ-040 Assert rst_n=0 mid-request with 3 entries queued -> all outputs at reset values immediately, restart at RESET_PC.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, fetch-queue FSM states and queue entry layout.
package pipe_pkg;

    localparam logic [5:0] OP_HLT   = 6'b111111;
    localparam logic [5:0] OP_BEQZ  = 6'b000100;
    localparam logic [5:0] OP_BNEQZ = 6'b000101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DISCARD,
        STOP
    } fq_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } fq_entry_t;

    function automatic logic is_hlt(input logic [31:0] instr);
        return instr[31:26] == OP_HLT;
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// Circular instruction queue with flush; pointers wrap modulo DEPTH.
module fq_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    input  logic                     push,
    input  fq_entry_t                push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fq_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    fq_entry_t       storage [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = storage[rd_ptr];

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: one outstanding memory read, branch redirect/discard and HLT stop.
module fetch_queue
    import pipe_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk1,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] npc,
    input  logic        ir_ready,
    output logic        halted
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fq_state_t       state;
    fq_state_t       next_state;
    logic [31:0]     pc;
    logic [31:0]     ir_hold;
    logic [31:0]     npc_hold;
    logic            redirect_eff;
    logic            push;
    logic            pop;
    logic            issue;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    fq_entry_t       head;
    fq_entry_t       push_data;

    assign redirect_eff = redirect_valid && !halted;
    assign pop          = !fifo_empty && ir_ready && !redirect_eff;
    assign push         = (state == BUSY) && imem_ack && !redirect_eff && (!fifo_full || pop);
    assign push_data    = '{instr: imem_rdata, npc: pc + 32'd1};

    assign imem_req = (state == BUSY) || (state == DISCARD);
    assign ir_valid = !fifo_empty;
    assign ir       = fifo_empty ? ir_hold  : head.instr;
    assign npc      = fifo_empty ? npc_hold : head.npc;

    fq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_eff),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A request is only issued while a free entry exists, so its response always fits.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!redirect_eff && !halted && (fifo_count < DEPTH_C)) begin
                    next_state = BUSY;
                    issue      = 1'b1;
                end
            end
            BUSY: begin
                if (imem_ack) begin
                    next_state = (!redirect_eff && is_hlt(imem_rdata)) ? STOP : IDLE;
                end else if (redirect_eff) begin
                    next_state = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_ack) next_state = IDLE;
            end
            STOP: begin
                if (redirect_eff) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            halted    <= 1'b0;
            ir_hold   <= 32'h0;
            npc_hold  <= 32'h0;
        end else begin
            state <= next_state;
            if (redirect_eff) begin
                pc <= redirect_pc;
            end else if (push) begin
                pc <= pc + 32'd1;
            end
            if (issue) imem_addr <= pc;
            if (pop && is_hlt(head.instr)) halted <= 1'b1;
            ir_hold  <= ir;
            npc_hold <= npc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model checked every cycle.
module tb_fetch_queue;
    import pipe_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
    } model_entry_t;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] npc;
    logic        ir_ready = 1'b0;
    logic        halted;

    logic [31:0] mem [0:63];
    int          mem_wait = 1;
    int          wait_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    model_entry_t mq[$];
    logic [31:0]  m_pc;
    logic         m_halted;
    logic         m_discard;
    logic [31:0]  hold_ir;
    logic [31:0]  hold_npc;
    logic         prev_req;
    logic [31:0]  prev_addr;
    logic [31:0]  c_ir[$];
    logic [31:0]  c_npc[$];

    always #5 clk1 = ~clk1;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_valid       (ir_valid),
        .ir             (ir),
        .npc            (npc),
        .ir_ready       (ir_ready),
        .halted         (halted)
    );

    // Memory answers a request after mem_wait extra cycles with a one-cycle ack.
    always begin
        @(posedge clk1);
        #1;
        if (!rst_n) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (imem_ack) begin
            imem_ack = 1'b0;
        end else if (imem_req) begin
            if (wait_cnt >= mem_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr[5:0]];
                wait_cnt   = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    task automatic model_reset();
        mq.delete();
        c_ir.delete();
        c_npc.delete();
        m_pc      = 32'h0;
        m_halted  = 1'b0;
        m_discard = 1'b0;
        hold_ir   = 32'h0;
        hold_npc  = 32'h0;
        prev_req  = 1'b0;
        prev_addr = 32'h0;
    endtask

    // Compare the DUT against the model, then advance the model to the next edge.
    task automatic step_model();
        logic        exp_valid;
        logic [31:0] exp_ir;
        logic [31:0] exp_npc;
        logic        redir;
        logic        hlt_q;
        exp_valid = (mq.size() != 0);
        exp_ir    = exp_valid ? mq[0].instr : hold_ir;
        exp_npc   = exp_valid ? mq[0].npc   : hold_npc;
        check_output("ir_valid", 32'(ir_valid), 32'(exp_valid));
        check_output("ir", ir, exp_ir);
        check_output("npc", npc, exp_npc);
        check_output("halted", 32'(halted), 32'(m_halted));
        if (imem_req && !prev_req) begin
            hlt_q = 1'b0;
            foreach (mq[i]) if (mq[i].instr[31:26] == OP_HLT) hlt_q = 1'b1;
            check_output("req_addr", imem_addr, m_pc);
            check_output("req_allowed", 32'(m_halted || hlt_q || mq.size() >= DEPTH), 32'd0);
        end else if (imem_req && prev_req) begin
            check_output("addr_stable", imem_addr, prev_addr);
        end
        hold_ir   = exp_ir;
        hold_npc  = exp_npc;
        prev_req  = imem_req;
        prev_addr = imem_addr;

        redir = redirect_valid && !m_halted;
        if (ir_valid && ir_ready && !redir) begin
            c_ir.push_back(ir);
            c_npc.push_back(npc);
        end
        if (redir) begin
            mq.delete();
            m_pc      = redirect_pc;
            m_discard = imem_req && !imem_ack;
        end else begin
            if (exp_valid && ir_ready) begin
                if (mq[0].instr[31:26] == OP_HLT) m_halted = 1'b1;
                void'(mq.pop_front());
            end
            if (imem_req && imem_ack) begin
                if (m_discard) begin
                    m_discard = 1'b0;
                end else begin
                    check_output("push_space", 32'(mq.size() < DEPTH), 32'd1);
                    mq.push_back('{instr: imem_rdata, npc: m_pc + 32'd1});
                    m_pc = m_pc + 32'd1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk1);
        if (rst_n) step_model();
        @(posedge clk1);
        #2;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values();
        check_output("rst_imem_req", 32'(imem_req), 32'd0);
        check_output("rst_imem_addr", imem_addr, 32'h0);
        check_output("rst_ir_valid", 32'(ir_valid), 32'd0);
        check_output("rst_ir", ir, 32'h0);
        check_output("rst_npc", npc, 32'h0);
        check_output("rst_halted", 32'(halted), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) mem[i] = {6'b001010, 26'(i)};
        mem[0]  = 32'h2801000a;
        mem[1]  = 32'h28020014;
        mem[2]  = 32'h28030019;
        mem[8]  = 32'hfc000000;
        mem[20] = 32'h28140005;

        // Reset values and first request
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values();
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        check_output("first_req", 32'(imem_req), 32'd1);
        check_output("first_addr", imem_addr, 32'h0);

        // ADDI stream with one-cycle memory
        ir_ready = 1'b1;
        for (n = 0; n < 40 && c_ir.size() < 3; n++) cycle();
        if (c_ir.size() < 3) begin
            report_timeout("addi_stream");
        end else begin
            check_output("addi0_ir", c_ir[0], 32'h2801000a);
            check_output("addi0_npc", c_npc[0], 32'd1);
            check_output("addi1_ir", c_ir[1], 32'h28020014);
            check_output("addi1_npc", c_npc[1], 32'd2);
            check_output("addi2_ir", c_ir[2], 32'h28030019);
            check_output("addi2_npc", c_npc[2], 32'd3);
        end

        // Full queue stops requests; one pop frees exactly one fetch
        ir_ready = 1'b0;
        mem_wait = 0;
        apply_reset();
        for (n = 0; n < 30 && mq.size() < DEPTH; n++) cycle();
        if (mq.size() < DEPTH) report_timeout("fill_queue");
        for (int k = 0; k < 6; k++) begin
            cycle();
            check_output("full_no_req", 32'(imem_req), 32'd0);
        end
        check_output("full_head", ir, 32'h2801000a);
        ir_ready = 1'b1;
        cycle();
        ir_ready = 1'b0;
        for (n = 0; n < 10 && !imem_req; n++) cycle();
        if (!imem_req) report_timeout("refill_req");
        else check_output("refill_addr", imem_addr, 32'd4);

        // Redirect while request to 5 is outstanding
        ir_ready = 1'b1;
        mem_wait = 3;
        apply_reset();
        for (n = 0; n < 60 && !(imem_req && imem_addr == 32'd5); n++) cycle();
        if (!(imem_req && imem_addr == 32'd5)) begin
            report_timeout("req_to_5");
        end else begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'd20;
            cycle();
            redirect_valid = 1'b0;
            c_ir.delete();
            c_npc.delete();
            for (n = 0; n < 40 && !(imem_req && imem_addr != 32'd5); n++) cycle();
            check_output("redirect_addr", imem_addr, 32'd20);
            for (n = 0; n < 40 && c_ir.size() < 1; n++) cycle();
            if (c_ir.size() < 1) begin
                report_timeout("redirect_data");
            end else begin
                check_output("redirect_ir", c_ir[0], 32'h28140005);
                check_output("redirect_npc", c_npc[0], 32'd21);
            end
        end

        // HLT at address 8 halts the queue
        mem_wait = 0;
        apply_reset();
        for (n = 0; n < 60 && !(c_ir.size() > 0 && c_ir[c_ir.size()-1] == 32'hfc000000); n++) cycle();
        if (!(c_ir.size() > 0 && c_ir[c_ir.size()-1] == 32'hfc000000)) begin
            report_timeout("hlt_pop");
        end else begin
            check_output("hlt_halted", 32'(halted), 32'd1);
            check_output("hlt_ir_valid", 32'(ir_valid), 32'd0);
            redirect_valid = 1'b1;
            redirect_pc    = 32'd0;
            cycle();
            redirect_valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                cycle();
                check_output("halt_no_req", 32'(imem_req), 32'd0);
            end
            check_output("halt_sticky", 32'(halted), 32'd1);
        end

        // HLT flushed by a redirect before it pops
        ir_ready = 1'b0;
        mem[2]   = 32'hfc000000;
        apply_reset();
        for (n = 0; n < 30 && mq.size() < 3; n++) cycle();
        if (mq.size() < 3) report_timeout("hlt_enqueue");
        for (int k = 0; k < 4; k++) begin
            cycle();
            check_output("stop_no_req", 32'(imem_req), 32'd0);
        end
        mem[2]         = 32'h28030019;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        cycle();
        redirect_valid = 1'b0;
        check_output("flush_halted", 32'(halted), 32'd0);
        check_output("flush_ir_valid", 32'(ir_valid), 32'd0);
        for (n = 0; n < 10 && !imem_req; n++) cycle();
        if (!imem_req) report_timeout("resume_req");
        else check_output("resume_addr", imem_addr, 32'd0);
        ir_ready = 1'b1;
        c_ir.delete();
        c_npc.delete();
        for (n = 0; n < 20 && c_ir.size() < 1; n++) cycle();
        if (c_ir.size() < 1) begin
            report_timeout("resume_data");
        end else begin
            check_output("resume_ir", c_ir[0], 32'h2801000a);
            check_output("resume_npc", c_npc[0], 32'd1);
        end

        // PC wrap from FFFFFFFF to 0
        apply_reset();
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFFF;
        cycle();
        redirect_valid = 1'b0;
        c_ir.delete();
        c_npc.delete();
        for (n = 0; n < 30 && c_ir.size() < 2; n++) cycle();
        if (c_ir.size() < 2) begin
            report_timeout("wrap_data");
        end else begin
            check_output("wrap_ir", c_ir[0], {6'b001010, 26'd63});
            check_output("wrap_npc", c_npc[0], 32'h0);
            check_output("wrap_next_ir", c_ir[1], 32'h2801000a);
            check_output("wrap_next_npc", c_npc[1], 32'd1);
        end

        // Asynchronous reset mid-request with three entries queued
        ir_ready = 1'b0;
        apply_reset();
        for (n = 0; n < 30 && !(mq.size() == 3 && imem_req); n++) cycle();
        if (!(mq.size() == 3 && imem_req)) report_timeout("mid_request");
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values();
        cycle();
        rst_n = 1'b1;
        cycle();
        check_output("restart_req", 32'(imem_req), 32'd1);
        check_output("restart_addr", imem_addr, 32'h0);
        for (int k = 0; k < 4; k++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
